// File: rtl/ets_pkg.sv
// Shared types and width helpers for the ETS phase sequencer.
package ets_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_CAPTURE,
        ST_NEXT
    } ets_state_t;

    localparam int DELAY_WIDTH_DEFAULT = 8;

    typedef logic [DELAY_WIDTH_DEFAULT-1:0] delay_code_t;

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold the value v.
    function automatic int cnt_width(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/ets_settle_timer.sv
// Loadable down-counter with zero flag; holds at zero.
module ets_settle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ets_phase_sequencer.sv
// ETS sweep controller: steps the PLL delay code, waits for lock+settle, then runs capture handshakes.
// Optional lock timeout in WAIT_LOCK is enabled by defining ETS_LOCK_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for start
// APPLY      | drive delay code for the current step
// WAIT_LOCK  | waiting for pll_lock
// SETTLE     | settle interval after lock
// CAPTURE    | capture_req / capture_ack handshakes
// NEXT       | advance step, wrap or finish the sweep
module ets_phase_sequencer
    import ets_pkg::*;
#(
    parameter int DELAY_WIDTH       = DELAY_WIDTH_DEFAULT,
    parameter int NUM_STEPS         = 16,
    parameter int STEP_SIZE         = 1,
    parameter int SETTLE_CYCLES     = 64,
    parameter int CAPTURES_PER_STEP = 4,
    parameter int LOCK_TIMEOUT      = 4096
) (
    input  logic                           ref_clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           continuous,
    input  logic                           abort,
    input  logic                           pll_lock,
    output logic [DELAY_WIDTH-1:0]         delay,
    output logic                           capture_req,
    input  logic                           capture_ack,
    output logic [idx_width(NUM_STEPS)-1:0] step_index,
    output logic                           busy,
    output logic                           sweep_done,
    output logic                           lock_error
);

    localparam int SW = idx_width(NUM_STEPS);
    localparam int CW = cnt_width(CAPTURES_PER_STEP);
    // One timer serves both the settle interval and the lock timeout.
    localparam int TMR_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int TW = cnt_width(TMR_MAX);

    localparam logic [SW-1:0] LAST_STEP   = SW'(NUM_STEPS - 1);
    localparam logic [CW-1:0] LAST_CAP    = CW'(CAPTURES_PER_STEP - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES);
`ifdef ETS_LOCK_TIMEOUT_EN
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(LOCK_TIMEOUT - 1);
`endif

    ets_state_t            state;
    logic [CW-1:0]         cap_count;
    logic                  cont_latched;
    logic                  tmr_load;
    logic                  tmr_dec;
    logic                  tmr_zero;
    logic [TW-1:0]         tmr_value;
    logic [DELAY_WIDTH-1:0] step_delay;

    assign step_delay = DELAY_WIDTH'(int'(step_index) * STEP_SIZE);

    always_comb begin
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_value = SETTLE_LOAD;
        case (state)
            ST_WAIT_LOCK: begin
                if (pll_lock) tmr_load = 1'b1;
                else          tmr_dec  = 1'b1;
            end
            ST_SETTLE: tmr_dec = 1'b1;
            default: ;
        endcase
`ifdef ETS_LOCK_TIMEOUT_EN
        // Arm the timeout on every entry into WAIT_LOCK.
        if ((state == ST_APPLY) ||
            (!pll_lock && ((state == ST_SETTLE) || (state == ST_CAPTURE)))) begin
            tmr_load  = 1'b1;
            tmr_value = TIMEOUT_LOAD;
        end
`endif
    end

    ets_settle_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk       (ref_clk),
        .reset     (reset),
        .load      (tmr_load),
        .dec       (tmr_dec),
        .load_value(tmr_value),
        .zero      (tmr_zero)
    );

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            delay        <= '0;
            capture_req  <= 1'b0;
            step_index   <= '0;
            busy         <= 1'b0;
            sweep_done   <= 1'b0;
            lock_error   <= 1'b0;
            cap_count    <= '0;
            cont_latched <= 1'b0;
        end else if (abort) begin
            state       <= ST_IDLE;
            delay       <= '0;
            capture_req <= 1'b0;
            step_index  <= '0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            cap_count   <= '0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_APPLY;
                        busy         <= 1'b1;
                        step_index   <= '0;
                        cont_latched <= continuous;
                        lock_error   <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    delay     <= step_delay;
                    cap_count <= '0;
                    state     <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (pll_lock) begin
                        state <= ST_SETTLE;
                    end
`ifdef ETS_LOCK_TIMEOUT_EN
                    else if (tmr_zero) begin
                        lock_error <= 1'b1;
                        delay      <= '0;
                        busy       <= 1'b0;
                        step_index <= '0;
                        state      <= ST_IDLE;
                    end
`endif
                end
                ST_SETTLE: begin
                    if (!pll_lock) begin
                        state <= ST_WAIT_LOCK;
                    end else if (tmr_zero) begin
                        state       <= ST_CAPTURE;
                        capture_req <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (!pll_lock) begin
                        capture_req <= 1'b0;
                        cap_count   <= '0;
                        state       <= ST_WAIT_LOCK;
                    end else if (capture_req) begin
                        if (capture_ack) begin
                            capture_req <= 1'b0;
                            if (cap_count == LAST_CAP) begin
                                state      <= ST_NEXT;
                                sweep_done <= (step_index == LAST_STEP);
                            end else begin
                                cap_count <= cap_count + 1'b1;
                            end
                        end
                    end else begin
                        capture_req <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (step_index != LAST_STEP) begin
                        step_index <= step_index + 1'b1;
                        state      <= ST_APPLY;
                    end else if (cont_latched) begin
                        step_index <= '0;
                        state      <= ST_APPLY;
                    end else begin
                        step_index <= '0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ets_phase_sequencer.sv
// Self-checking bench for ets_phase_sequencer: capture scoreboard plus scenario table and timing sequences.
module tb_ets_phase_sequencer;

    localparam int DW  = 8;
    localparam int NS  = 4;
    localparam int SS  = 3;
    localparam int SC  = 5;
    localparam int CPS = 4;
    localparam int LT  = 100;

    logic          ref_clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          abort = 1'b0;
    logic          pll_lock = 1'b1;
    logic          capture_ack = 1'b0;
    logic [DW-1:0] delay;
    logic          capture_req;
    logic [1:0]    step_index;
    logic          busy;
    logic          sweep_done;
    logic          lock_error;

    ets_phase_sequencer #(
        .DELAY_WIDTH      (DW),
        .NUM_STEPS        (NS),
        .STEP_SIZE        (SS),
        .SETTLE_CYCLES    (SC),
        .CAPTURES_PER_STEP(CPS),
        .LOCK_TIMEOUT     (LT)
    ) dut (
        .ref_clk    (ref_clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .pll_lock   (pll_lock),
        .delay      (delay),
        .capture_req(capture_req),
        .capture_ack(capture_ack),
        .step_index (step_index),
        .busy       (busy),
        .sweep_done (sweep_done),
        .lock_error (lock_error)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct {
        int step;
        int dly;
    } cap_t;

    typedef struct {
        bit cont;
        int drop_step;
        bit noise;
        int exp_acks;
        int exp_done;
    } scen_t;

    int   n_vec = 0;
    int   n_err = 0;
    cap_t exp_q[$];
    int   ack_total = 0;
    int   done_count = 0;
    int   step_acks[NS];
    bit   ack_en = 1'b0;
    bit   noise = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every accepted handshake pops one expected {step, delay}.
    always @(negedge ref_clk) begin
        cap_t e;
        if (!reset && !abort && capture_req && capture_ack) begin
            ack_total++;
            step_acks[step_index]++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_capture: got step %0d delay %0d, expected no capture", step_index, delay);
            end else begin
                e = exp_q.pop_front();
                check("capture_step", 32'(step_index), 32'(e.step));
                check("capture_delay", 32'(delay), 32'(e.dly));
            end
        end
        if (!reset && sweep_done) done_count++;
    end

    // Sampler model: ack one cycle after req, one cycle wide; optional stray acks while req is low.
    initial forever begin
        @(posedge ref_clk);
        #1;
        if (capture_ack) capture_ack = 1'b0;
        else if (ack_en && capture_req) capture_ack = 1'b1;
        else if (noise && !capture_req && ($urandom_range(0, 2) == 0)) capture_ack = 1'b1;
    end

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic clear_counts();
        ack_total  = 0;
        done_count = 0;
        for (int i = 0; i < NS; i++) step_acks[i] = 0;
    endtask

    task automatic push_step(input int s, input int n);
        for (int c = 0; c < n; c++) exp_q.push_back('{s, s * SS});
    endtask

    task automatic push_sweep(input int drop_step);
        for (int s = 0; s < NS; s++) push_step(s, (s == drop_step) ? CPS + 2 : CPS);
    endtask

    task automatic pulse_start(input bit c);
        start = 1'b1;
        continuous = c;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_busy_low(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_acks(input int s, input int cnt);
        int n = 0;
        while (step_acks[s] < cnt && n < 2000) begin
            tick();
            n++;
        end
        check("wait_acks_reached", 32'(step_acks[s] >= cnt), 32'd1);
    endtask

    scen_t scen[4];

    initial begin
        int n;
        bit dropped;
        int busy_low;

        scen[0] = '{1'b0,  2, 1'b0, 4 * CPS + 2, 1};
        scen[1] = '{1'b1, -1, 1'b0, 8 * CPS,     2};
        scen[2] = '{1'b0,  0, 1'b0, 4 * CPS + 2, 1};
        scen[3] = '{1'b0, -1, 1'b1, 4 * CPS,     1};

        // Reset state
        repeat (3) tick();
        check("rst_delay", 32'(delay), 32'd0);
        check("rst_req", 32'(capture_req), 32'd0);
        check("rst_step", 32'(step_index), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(sweep_done), 32'd0);
        check("rst_lock_error", 32'(lock_error), 32'd0);
        reset = 1'b0;
        tick();

        // Single sweep with latency checks
        clear_counts();
        ack_en = 1'b1;
        push_sweep(-1);
        pulse_start(1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        n = 0;
        while (!capture_req && n < 100) begin
            tick();
            n++;
        end
        check("first_req_latency", 32'(n), 32'(SC + 3));
        wait_acks(0, 1);
        check("req_low_after_ack", 32'(capture_req), 32'd0);
        tick();
        check("req_reasserted", 32'(capture_req), 32'd1);
        wait_acks(0, CPS);
        check("req_low_after_last_ack", 32'(capture_req), 32'd0);
        tick();
        check("step_after_next", 32'(step_index), 32'd1);
        check("delay_held_in_apply", 32'(delay), 32'd0);
        tick();
        check("new_delay", 32'(delay), 32'(SS));
        wait_busy_low("sweep_end_busy");
        check("sweep_acks", 32'(ack_total), 32'(4 * CPS));
        check("sweep_done_count", 32'(done_count), 32'd1);
        check("sweep_queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_step", 32'(step_index), 32'd0);
        tick();

        // Scenario table
        for (int t = 0; t < 4; t++) begin
            clear_counts();
            exp_q.delete();
            if (scen[t].cont) begin
                push_sweep(-1);
                push_sweep(-1);
            end else begin
                push_sweep(scen[t].drop_step);
            end
            noise = scen[t].noise;
            pulse_start(scen[t].cont);
            if (scen[t].noise) continuous = 1'b1;
            n = 0;
            dropped = 1'b0;
            busy_low = 0;
            while (n < 4000) begin
                start = 1'b0;
                if (scen[t].cont ? (done_count >= 2) : !busy) break;
                if (!busy) busy_low++;
                if (scen[t].drop_step >= 0 && !dropped && step_acks[scen[t].drop_step] == 2) begin
                    dropped = 1'b1;
                    pll_lock = 1'b0;
                    tick();
                    check("req_low_on_lock_drop", 32'(capture_req), 32'd0);
                    repeat (4) tick();
                    pll_lock = 1'b1;
                    n += 5;
                end
                if (scen[t].noise && busy) start = ($urandom_range(0, 3) == 0);
                tick();
                n++;
            end
            start = 1'b0;
            noise = 1'b0;
            continuous = 1'b0;
            if (scen[t].cont) begin
                check("busy_through_wrap", 32'(busy_low), 32'd0);
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            check("scen_busy_end", 32'(busy), 32'd0);
            check("scen_acks", 32'(ack_total), 32'(scen[t].exp_acks));
            check("scen_done", 32'(done_count), 32'(scen[t].exp_done));
            check("scen_queue_empty", 32'(exp_q.size()), 32'd0);
            check("scen_lock_error", 32'(lock_error), 32'd0);
            tick();
        end

        // Abort during SETTLE of step 1, restart one cycle later
        clear_counts();
        exp_q.delete();
        push_step(0, CPS);
        pulse_start(1'b0);
        n = 0;
        while (!(step_index == 2'd1 && delay == DW'(SS)) && n < 2000) begin
            tick();
            n++;
        end
        check("abort_reached_step1", 32'(delay), 32'(SS));
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_delay", 32'(delay), 32'd0);
        check("abort_req", 32'(capture_req), 32'd0);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        clear_counts();
        push_sweep(-1);
        pulse_start(1'b0);
        check("restart_busy", 32'(busy), 32'd1);
        wait_busy_low("restart_end_busy");
        check("restart_acks", 32'(ack_total), 32'(4 * CPS));
        check("restart_done", 32'(done_count), 32'd1);
        check("restart_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Reset mid-sweep
        clear_counts();
        exp_q.delete();
        push_step(0, CPS);
        push_step(1, 2);
        pulse_start(1'b0);
        wait_acks(1, 2);
        reset = 1'b1;
        tick();
        check("midrst_delay", 32'(delay), 32'd0);
        check("midrst_req", 32'(capture_req), 32'd0);
        check("midrst_step", 32'(step_index), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(sweep_done), 32'd0);
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        tick();

        // Lock never arrives
        clear_counts();
        exp_q.delete();
        pll_lock = 1'b0;
        pulse_start(1'b0);
`ifdef ETS_LOCK_TIMEOUT_EN
        repeat (LT) tick();
        check("timeout_not_yet", 32'(lock_error), 32'd0);
        check("timeout_busy_before", 32'(busy), 32'd1);
        tick();
        check("timeout_lock_error", 32'(lock_error), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_delay", 32'(delay), 32'd0);
        check("timeout_no_done", 32'(done_count), 32'd0);
        pll_lock = 1'b1;
        repeat (3) tick();
        check("lock_error_sticky", 32'(lock_error), 32'd1);
        pulse_start(1'b0);
        check("lock_error_cleared", 32'(lock_error), 32'd0);
`else
        repeat (LT + 20) tick();
        check("no_timeout_lock_error", 32'(lock_error), 32'd0);
        check("no_timeout_busy", 32'(busy), 32'd1);
        pll_lock = 1'b1;
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("final_busy", 32'(busy), 32'd0);
        check("final_done", 32'(done_count), 32'd0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ets_phase_sequencer.md
# ets_phase_sequencer

Parametrised sweep controller for the equivalent-time-sampling (ETS) front end. It steps the PLL dynamic-delay code through a programmable series of phase offsets. At each step it waits for PLL lock plus a settle interval, then requests a fixed number of captures from the sampler before advancing. It sits between the capture/readout logic and the phase-offset PLL wrapper, and runs in the reference-clock domain.

## Interface
Parameters:
- DELAY_WIDTH, 8, width of the PLL dynamic-delay code.
- NUM_STEPS, 16, number of phase steps per sweep (≥2).
- STEP_SIZE, 1, delay-code increment per step; (NUM_STEPS-1)*STEP_SIZE must be < 2^DELAY_WIDTH.
- SETTLE_CYCLES, 64, cycles to wait after lock is seen before capturing (≥1).
- CAPTURES_PER_STEP, 4, capture handshakes per step (≥1).
- LOCK_TIMEOUT, 4096, WAIT_LOCK cycle limit (used only with ETS_LOCK_TIMEOUT_EN).

Ports:
- ref_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin sweep; honoured only in IDLE.
- continuous  in  1  sampled at start; 1 = wrap and sweep forever.
- abort  in  1  return to IDLE from any state.
- pll_lock  in  1  PLL lock indicator (treated as synchronous).
- delay  out  DELAY_WIDTH  registered dynamic-delay code to the PLL.
- capture_req  out  1  request one capture.
- capture_ack  in  1  capture completed.
- step_index  out  clog2(NUM_STEPS)  current step.
- busy  out  1  high in any state but IDLE.
- sweep_done  out  1  one-cycle pulse at the end of each sweep.
- lock_error  out  1  sticky lock-timeout flag.

## Operation
- States: IDLE, APPLY, WAIT_LOCK, SETTLE, CAPTURE, NEXT.
- IDLE: if start → APPLY; step_index=0; latch continuous; clear lock_error.
- APPLY: delay ← step_index*STEP_SIZE (truncated to DELAY_WIDTH); capture count ← 0 → WAIT_LOCK.
- WAIT_LOCK: when pll_lock=1, load settle timer with SETTLE_CYCLES → SETTLE.
- SETTLE: decrement each cycle. pll_lock=0 → WAIT_LOCK. Timer reaching 0 → CAPTURE.
- CAPTURE: capture_req=1 until capture_ack is sampled 1. capture_req is 0 for at least one cycle between requests. Each ack increments the capture count. After CAPTURES_PER_STEP acks → NEXT. If pll_lock drops, capture_req falls, the capture count clears, and the FSM goes to WAIT_LOCK (the step is redone).
- NEXT: if step_index<NUM_STEPS-1 → step_index+1, APPLY. Otherwise pulse sweep_done; if latched continuous → step_index=0, APPLY; else → IDLE.
- abort (highest priority after reset): → IDLE next cycle; capture_req=0; delay=0; no sweep_done.
- start while busy is ignored. An ack arriving while capture_req=0 is ignored.

## Timing
- Reset values: delay=0, capture_req=0, step_index=0, busy=0, sweep_done=0, lock_error=0, state IDLE.
- start at cycle N → busy=1 at N+1, delay valid at N+2.
- With pll_lock held high: first capture_req rises SETTLE_CYCLES+2 cycles after entering WAIT_LOCK.
- ack sampled at cycle M → capture_req=0 at M+1, reasserted at M+2 if more captures are due.
- Last ack of a step → NEXT at M+1, new delay at M+3.
- sweep_done is asserted in the NEXT cycle of the final step, exactly one cycle wide.
- Reset mid-sweep: all outputs return to reset values on the next edge.

## Configuration
- ETS_LOCK_TIMEOUT_EN defined:
  - WAIT_LOCK counts cycles. At LOCK_TIMEOUT without lock: lock_error←1, delay←0, → IDLE, no sweep_done.
  - lock_error stays set until the next accepted start or reset.
- ETS_LOCK_TIMEOUT_EN undefined: WAIT_LOCK waits indefinitely; lock_error is tied to 0.

## Structure
- Shared package ets_pkg: state enum, clog2-based width constants, and the delay-code type sized by DELAY_WIDTH.
- One sub-module, ets_settle_timer: loadable down-counter with a zero flag. It is reused for the settle interval and, when enabled, the lock timeout.

## Test plan
- NUM_STEPS=4, STEP_SIZE=3, pll_lock=1, ack one cycle after each req → delay sequence 0,3,6,9; 4×CAPTURES_PER_STEP acks; single sweep_done; then IDLE.
- pll_lock dropped for 5 cycles mid-CAPTURE at step 2 (after 2 acks) → capture_req falls, step 2 is redone with a full settle, and 4 acks are counted for step 2.
- continuous=1 over 2 sweeps → step_index wraps 3→0, sweep_done pulses twice, busy stays high.
- abort during SETTLE, then start one cycle later → delay=0, busy=0, then a clean restart from step 0.
- With ETS_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=100, pll_lock=0 → lock_error=1 after 100 WAIT_LOCK cycles, IDLE, no sweep_done; the next start clears lock_error.
- start pulsed while busy, and ack pulsed while capture_req=0 → neither has any effect.
